// File: rtl/dot_product_pkg.sv
// rtl/dot_product_pkg.sv - shared helpers for the parametrised dot-product engine
package dot_product_pkg;

  // Widest product/accumulator the extension helper can handle
  localparam int EXT_W = 256;

  // Sideband that travels alongside each pipeline beat
  typedef struct packed {
    logic valid;
    logic last;
  } side_t;

  // Ceiling log2; clog2(1) = 0
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < value) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

  // Cycles from the accepting edge (counted as the first) to out_valid rising
  function automatic int DP_LATENCY(input int n);
    return clog2(n) + 2;
  endfunction

  // Sign- or zero-extend the low prod_w bits of prod to EXT_W bits
  function automatic logic [EXT_W-1:0] extend_product(input logic [EXT_W-1:0] prod,
                                                      input int prod_w,
                                                      input bit is_signed);
    logic [EXT_W-1:0] mask;
    mask = (EXT_W'(1) << prod_w) - EXT_W'(1);
    if (is_signed && prod[8'(prod_w - 1)]) begin
      return prod | ~mask;
    end
    return prod & mask;
  endfunction

endpackage

// File: rtl/dot_product_param_tree.sv
// rtl/dot_product_param_tree.sv - registered binary adder tree with valid/last sideband
module dp_adder_tree
  import dot_product_pkg::*;
#(
  parameter int N     = 4,
  parameter int ACC_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               adv,
  input  logic               in_valid,
  input  logic               in_last,
  input  logic [N*ACC_W-1:0] in_data,
  output logic               out_valid,
  output logic               out_last,
  output logic [ACC_W-1:0]   sum
);

  localparam int K = clog2(N);

  // Level 0 is the unregistered input; levels 1..K are one register stage each.
  // Each level holds exactly ceil(N / 2^l) operands so every bit is consumed.
  for (genvar l = 0; l <= K; l++) begin : g_lvl
    localparam int CUR = (N + (1 << l) - 1) >> l;
    logic [CUR*ACC_W-1:0] data;
    side_t                side;

    if (l == 0) begin : g_in
      assign data = in_data;
      assign side = side_t'{valid: in_valid, last: in_last};
    end else begin : g_reg
      localparam int PREV = (N + (1 << (l - 1)) - 1) >> (l - 1);
      logic [CUR*ACC_W-1:0] nxt;

      for (genvar j = 0; j < CUR; j++) begin : g_node
        if (2 * j + 1 < PREV) begin : g_add
          assign nxt[j*ACC_W +: ACC_W] = g_lvl[l-1].data[(2*j)*ACC_W +: ACC_W]
                                       + g_lvl[l-1].data[(2*j+1)*ACC_W +: ACC_W];
        end else begin : g_pass
          // Odd leftover operand rides through this level unchanged
          assign nxt[j*ACC_W +: ACC_W] = g_lvl[l-1].data[(2*j)*ACC_W +: ACC_W];
        end
      end

      // Tree level register: holds on stall, clears on reset
      always_ff @(posedge clk) begin
        if (reset) begin
          data <= '0;
          side <= '0;
        end else if (adv) begin
          data <= nxt;
          side <= g_lvl[l-1].side;
        end
      end
    end
  end

  assign sum       = g_lvl[K].data;
  assign out_valid = g_lvl[K].side.valid;
  assign out_last  = g_lvl[K].side.last;

endmodule

// File: rtl/dot_product_param.sv
// rtl/dot_product_param.sv - pipelined N-element dot product with multi-beat accumulate
module dot_product_param
  import dot_product_pkg::*;
#(
  parameter int N      = 4,
  parameter int DATA_W = 8,
  parameter int SIGNED = 0,
  parameter int ACC_W  = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_last,
  input  logic [N*DATA_W-1:0] a_flat,
  input  logic [N*DATA_W-1:0] b_flat,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ACC_W-1:0]    result
);

  localparam int PROD_W = 2 * DATA_W;

  // One global advance: the whole pipeline moves or the whole pipeline holds
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Products, each extended to the accumulator width
  logic [N*ACC_W-1:0] prod_ext;

  for (genvar i = 0; i < N; i++) begin : g_mul
    logic [DATA_W-1:0] a_e;
    logic [DATA_W-1:0] b_e;
    logic [PROD_W-1:0] a_x;
    logic [PROD_W-1:0] b_x;
    logic [PROD_W-1:0] prod;

    assign a_e = a_flat[i*DATA_W +: DATA_W];
    assign b_e = b_flat[i*DATA_W +: DATA_W];

    // Extending operands to the product width makes the low PROD_W bits exact
    if (SIGNED != 0) begin : g_sx
      assign a_x = {{DATA_W{a_e[DATA_W-1]}}, a_e};
      assign b_x = {{DATA_W{b_e[DATA_W-1]}}, b_e};
    end else begin : g_zx
      assign a_x = {{DATA_W{1'b0}}, a_e};
      assign b_x = {{DATA_W{1'b0}}, b_e};
    end

    assign prod = a_x * b_x;
    assign prod_ext[i*ACC_W +: ACC_W] =
      ACC_W'(extend_product(EXT_W'(prod), PROD_W, SIGNED != 0));
  end

  // Stage M registers
  logic               m_valid;
  logic               m_last;
  logic [N*ACC_W-1:0] m_data;

  // Stage M: capture products with their sideband; last is only meaningful on a valid beat
  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_data  <= '0;
    end else if (adv) begin
      m_valid <= in_valid;
      m_last  <= in_valid && in_last;
      m_data  <= prod_ext;
    end
  end

  // Adder tree
  logic             t_valid;
  logic             t_last;
  logic [ACC_W-1:0] t_sum;

  dp_adder_tree #(
    .N     (N),
    .ACC_W (ACC_W)
  ) u_tree (
    .clk       (clk),
    .reset     (reset),
    .adv       (adv),
    .in_valid  (m_valid),
    .in_last   (m_last),
    .in_data   (m_data),
    .out_valid (t_valid),
    .out_last  (t_last),
    .sum       (t_sum)
  );

  // Stage A: accumulator and output register
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_next;

  assign acc_next = acc + t_sum;

  // Accumulate non-final beats; a final beat publishes the packet sum and clears acc.
  // When advancing without a final beat, the old result has been taken, so drop out_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= '0;
      result    <= '0;
      out_valid <= 1'b0;
    end else if (adv) begin
      if (t_valid && t_last) begin
        result    <= acc_next;
        acc       <= '0;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
        if (t_valid) begin
          acc <= acc_next;
        end
      end
    end
  end

endmodule
